// File: rtl/instr_seq_pkg.sv
// -----------------------------------------------------------------------------
// instr_seq_pkg
// Shared types and constants for the instruction sequencer.
//   INSTR_W            : width of one instruction word (16)
//   instr_seq_state_t  : sequencer FSM states. ST_ERR only exists when the
//                        build defines INSTR_SEQ_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package instr_seq_pkg;

   localparam int INSTR_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_START     = 3'd2,
      ST_WAIT_BUSY = 3'd3,
      ST_WAIT_DONE = 3'd4,
`ifdef INSTR_SEQ_TIMEOUT_EN
      ST_DONE      = 3'd5,
      ST_ERR       = 3'd6
`else
      ST_DONE      = 3'd5
`endif
   } instr_seq_state_t;

endpackage

// File: rtl/instr_seq_mem.sv
// -----------------------------------------------------------------------------
// instr_seq_mem
// Program buffer: DEPTH x INSTR_W register array, synchronous write port,
// asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clk     : rising-edge clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : word to write
//   rd_addr : read address (the sequencer's next pc)
//   rd_data : word at rd_addr, combinational
// -----------------------------------------------------------------------------
module instr_seq_mem
   import instr_seq_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [INSTR_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [INSTR_W-1:0] rd_data
);

   logic [INSTR_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Issues a host-written program to the Simple RISC Machine CPU one
// instruction at a time: present the word on cpu_in, pulse cpu_load, pulse
// cpu_s, then wait for cpu_w to fall and rise again before moving on.
// Optional feature macro: INSTR_SEQ_TIMEOUT_EN adds a per-instruction wait
// timeout (TIMEOUT_CYCLES) with an ERR state and a sticky err flag; without
// it the block waits forever and err is tied low.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   wr_en/addr/data   : host program-buffer write port (IDLE only)
//   prog_len          : instruction count 0..DEPTH, sampled on accepted go
//   go                : start request, honoured only in IDLE
//   cpu_in            : registered instruction word to the CPU
//   cpu_load, cpu_s   : one-cycle load / start pulses to the CPU
//   cpu_w             : CPU wait flag (high = CPU idle)
//   busy, done, err   : status (not IDLE / completion pulse / sticky timeout)
//   pc                : index of the current instruction
// -----------------------------------------------------------------------------
module instr_sequencer
   import instr_seq_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int ADDR_W         = $clog2(DEPTH),
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [INSTR_W-1:0] wr_data,
   input  logic [ADDR_W:0]    prog_len,
   input  logic               go,
   output logic [INSTR_W-1:0] cpu_in,
   output logic               cpu_load,
   output logic               cpu_s,
   input  logic               cpu_w,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [ADDR_W-1:0]  pc
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("instr_sequencer: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
   end

   instr_seq_state_t   state, next_state;
   logic [ADDR_W:0]    len;
   logic [ADDR_W-1:0]  rd_addr;
   logic [INSTR_W-1:0] rd_data;
   logic               last;
   logic               timeout_hit;

   // Read port looks ahead: mem[0] while idle, mem[pc+1] otherwise.
   assign rd_addr = (state == ST_IDLE) ? '0 : pc + 1'b1;
   assign last    = ({1'b0, pc} == (len - (ADDR_W+1)'(1)));

   instr_seq_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en && (state == ST_IDLE)),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

`ifdef INSTR_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             waiting;
   logic             err_q;

   assign waiting     = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);
   assign timeout_hit = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign err         = err_q;

   // Clearing in START means the count starts at zero on WAIT_BUSY entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == ST_START) wait_cnt <= '0;
         else if (waiting)      wait_cnt <= wait_cnt + 1'b1;

         if (state == ST_IDLE && go) err_q <= 1'b0;
         else if (timeout_hit)       err_q <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:      if (go) next_state = (prog_len == '0) ? ST_DONE : ST_LOAD;
         ST_LOAD:      next_state = ST_START;
         ST_START:     next_state = ST_WAIT_BUSY;
         // cpu_w may still read 1 just after cpu_s; wait for it to fall first.
         ST_WAIT_BUSY: if (!cpu_w) next_state = ST_WAIT_DONE;
         ST_WAIT_DONE: if (cpu_w)  next_state = last ? ST_DONE : ST_LOAD;
         ST_DONE:      next_state = ST_IDLE;
`ifdef INSTR_SEQ_TIMEOUT_EN
         ST_ERR:       next_state = ST_IDLE;
`endif
         default:      next_state = ST_IDLE;
      endcase
`ifdef INSTR_SEQ_TIMEOUT_EN
      if (timeout_hit) next_state = ST_ERR;
`endif
   end

   // Outputs decoded from state so reset drops the pulses immediately.
   always_comb begin
      cpu_load = (state == ST_LOAD);
      cpu_s    = (state == ST_START);
      busy     = (state != ST_IDLE);
      done     = (state == ST_DONE);
   end

   // Program length, pc and the instruction word register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len    <= '0;
         pc     <= '0;
         cpu_in <= '0;
      end else begin
         if (state == ST_IDLE && go) begin
            len <= prog_len;
            pc  <= '0;
         end else if (state == ST_WAIT_DONE && next_state == ST_LOAD) begin
            pc  <= pc + 1'b1;
         end
         if (next_state == ST_LOAD) cpu_in <= rd_data;
      end
   end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program sequencer that initiates the Simple RISC Machine CPU instruction handshake. It holds a small program buffer that a host writes, and on `go` issues each instruction to the CPU in order. For each instruction it presents the word on `cpu_in`, pulses `cpu_load`, then pulses `cpu_s`, and waits for the CPU's `w` to complete. It sits between a host or test harness and the `cpu` block, driving the `in`/`load`/`s` ports that a bench otherwise drives by hand.

## Interface
- `DEPTH`, 16: program buffer entries; must be a power of two, at least 2.
- `ADDR_W`, `$clog2(DEPTH)`: buffer address width.
- `TIMEOUT_CYCLES`, 64: maximum cycles spent waiting on `cpu_w` per instruction. Only used when the timeout feature is compiled in.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `wr_en` input 1: host write strobe to the program buffer.
- `wr_addr` input ADDR_W: write address.
- `wr_data` input 16: instruction word to write.
- `prog_len` input ADDR_W+1: number of instructions to run, 0..DEPTH. Sampled when `go` is accepted.
- `go` input 1: start request, accepted only in IDLE.
- `cpu_in` output 16: instruction word to the CPU (registered).
- `cpu_load` output 1: one-cycle load pulse to the CPU.
- `cpu_s` output 1: one-cycle start pulse to the CPU.
- `cpu_w` input 1: CPU wait flag; high means the CPU is idle and waiting.
- `busy` output 1: high whenever the block is not in IDLE.
- `done` output 1: one-cycle pulse when the program completes.
- `err` output 1: sticky timeout flag.
- `pc` output ADDR_W: index of the current instruction.

## Operation
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, DONE, and ERR (ERR exists only with the timeout feature).
- IDLE:
  - `wr_en` writes `wr_data` to `mem[wr_addr]`.
  - When `go` is high: latch `prog_len` and clear `pc` and `err`.
  - If the latched length is 0, go to DONE. Otherwise load `cpu_in` with `mem[0]` and go to LOAD.
- LOAD: `cpu_load`=1 for exactly one cycle, then go to START.
- START: `cpu_s`=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: stay until `cpu_w`=0, then go to WAIT_DONE. This rejects the stale `w`=1 the CPU shows before it leaves its wait state.
- WAIT_DONE: stay until `cpu_w`=1. Then:
  - If `pc` equals length−1, go to DONE.
  - Otherwise increment `pc`, load `cpu_in` with `mem[pc+1]`, and go to LOAD.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `cpu_in` holds its value from LOAD through WAIT_DONE and keeps its last value in IDLE.
- `wr_en` is ignored whenever `busy`=1.
- `go` outside IDLE is ignored.
- `pc` wraps naturally. `prog_len`=DEPTH runs all entries, and the last `pc` is DEPTH−1.

## Timing
- Reset values (asynchronous):
  - state = IDLE
  - `cpu_in`=0, `cpu_load`=0, `cpu_s`=0
  - `busy`=0, `done`=0, `err`=0, `pc`=0
  - Buffer contents are not reset.
- From `go` sampled to `cpu_load` high: 1 cycle.
- From `cpu_load` to `cpu_s`: 1 cycle.
- From `cpu_w` sampled rising in WAIT_DONE to the next `cpu_load`: 1 cycle.
- Minimum per instruction: 4 cycles, plus however long the CPU takes to execute.
- A write in the same cycle as an accepted `go` commits, but is not visible to the first read: `mem[0]` is read before the write lands.
- Reset asserted mid-program returns to IDLE immediately. `cpu_load` and `cpu_s` drop asynchronously, and no `done` pulse is produced.

## Configuration
- `INSTR_SEQ_TIMEOUT_EN` defined:
  - A cycle counter is cleared on entry to WAIT_BUSY and counts in WAIT_BUSY and WAIT_DONE.
  - When it reaches `TIMEOUT_CYCLES`, go to ERR.
  - ERR sets `err`=1 and goes to IDLE next cycle, without a `done` pulse.
  - `err` stays set until reset or the next accepted `go`.
- `INSTR_SEQ_TIMEOUT_EN` undefined:
  - No counter and no ERR state; the block waits indefinitely.
  - `err` is tied to 0.

## Structure
- Package `instr_seq_pkg` holds:
  - the state enum `instr_seq_state_t`
  - the constant `INSTR_W`=16
- Sub-module `instr_seq_mem`: a DEPTH×16 register array with a synchronous write port and an asynchronous read port indexed by the next `pc`.

## Test plan
- **Three-instruction program on the real `cpu`:** load D007, D102, A140 and run with `prog_len`=3, `go`=1.
  - Required: R0=7, R1=2, R2=9, exactly one `done` pulse, and `pc`=2 when `done` is seen.
- **Zero-length program:** `prog_len`=0, `go`=1.
  - Required: `done` the cycle after DONE is entered, no `cpu_load` or `cpu_s` pulses, `busy` high for exactly 1 cycle.
- **Behavioural CPU model that holds `w`=1 for 3 cycles after `s` before dropping it:**
  - Required: the sequencer stays in WAIT_BUSY and issues no second `cpu_load` until `w` has gone 0 then 1.
- **Writes and `go` while busy:** pulse `wr_en` (addr 1 ← FFFF) and `go` during a run.
  - Required: `mem[1]` is unchanged, and no restart occurs.
- **Reset mid-program:** assert `reset` during WAIT_DONE of instruction 1 of 3.
  - Required: all outputs reach their reset values within the same cycle, and no `done` is produced.
- **Timeout (with `INSTR_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8):** the model never raises `w`.
  - Required: `err`=1 eight cycles after WAIT_BUSY entry, `busy`=0 the following cycle, and `err` clears on the next `go`.
